wshb_mire: RTL and testbench

WSHB_MIRE -- requirements
Module: wshb_mire

---
 rtl/video_pkg.sv | 22 ++
 rtl/wshb_if.sv | 17 +
 rtl/mire_pixel_counter.sv | 50 +++++
 rtl/wshb_mire.sv | 115 +++++++++++
 tb/tb_wshb_mire.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: display defaults, Wishbone constants, pixel/word
// types and the test-pattern colour rule.
package video_pkg;

    localparam int HDISP_DEFAULT = 800;
    localparam int VDISP_DEFAULT = 480;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    typedef logic [23:0] pixel_t;
    typedef logic [31:0] word_t;

    localparam pixel_t PIX_WHITE = 24'hFF_FFFF;
    localparam pixel_t PIX_BLACK = 24'h00_0000;

    // Grid pattern: a white line every 16 columns and every 16 rows.
    function automatic word_t mire_word(input word_t x, input word_t y);
        return {8'h00, ((x % 32'd16 == 32'd0) || (y % 32'd16 == 32'd0)) ? PIX_WHITE : PIX_BLACK};
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus with 32-bit data and address, master/slave views.
interface wshb_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (output cyc, stb, we, sel, adr, dat_ms, cti, bte, input ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_ms, cti, bte, output ack);

endinterface

// File: rtl/mire_pixel_counter.sv
// Raster x/y counter with line and frame wrap; shared with the VGA read master.
module mire_pixel_counter #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int XW    = (HDISP > 1) ? $clog2(HDISP) : 1,
    parameter int YW    = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [XW-1:0] x_next,
    output logic [YW-1:0] y_next,
    output logic          last
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;

    assign x_last = (x == XW'(HDISP - 1));
    assign y_last = (y == YW'(VDISP - 1));
    assign last   = x_last && y_last;

    // x_next/y_next are the coordinates after this edge, so callers can
    // register data for the next pixel without a cycle of lag.
    always_comb begin
        x_next = x;
        y_next = y;
        if (advance) begin
            if (x_last) begin
                x_next = '0;
                y_next = y_last ? '0 : y + YW'(1);
            end else begin
                x_next = x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone write master filling the frame buffer with a grid test pattern,
// releasing the bus for one cycle after every BURST_LEN acknowledged writes.
module wshb_mire
    import video_pkg::*;
#(
    parameter int          HDISP     = HDISP_DEFAULT,
    parameter int          VDISP     = VDISP_DEFAULT,
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter int          BURST_LEN = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    wshb_if.master wshb_ifm,
    output logic   frame_done
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

    state_t        state;
    logic          cyc;
    word_t         adr;
    word_t         dat;
    logic [BW-1:0] burst_cnt;

    logic          advance;
    logic          last;
    logic          burst_end;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    word_t         next_adr;

    assign advance   = (state == WRITE) && wshb_ifm.ack;
    assign burst_end = (burst_cnt == BW'(BURST_LEN - 1));
    assign next_adr  = BASE_ADR + ((word_t'(y_next) * word_t'(HDISP) + word_t'(x_next)) << 2);

    mire_pixel_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .x_next  (x_next),
        .y_next  (y_next),
        .last    (last)
    );

    // NOTE: every register here, including adr/dat, gets a reset value so the
    // bus is idle and the first write targets pixel (0,0) straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cyc        <= 1'b0;
            burst_cnt  <= '0;
            frame_done <= 1'b0;
            adr        <= BASE_ADR;
            dat        <= mire_word(32'd0, 32'd0);
        end else begin
            frame_done <= advance && last;
            if (advance) begin
                adr <= next_adr;
                dat <= mire_word(word_t'(x_next), word_t'(y_next));
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= WRITE;
                        cyc   <= 1'b1;
                    end
                end
                WRITE: begin
                    // Without ack we hold everything, even if en has dropped.
                    if (wshb_ifm.ack) begin
                        if (burst_end) begin
                            burst_cnt <= '0;
                            state     <= RELEASE;
                            cyc       <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                            if (!en) begin
                                state <= IDLE;
                                cyc   <= 1'b0;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state <= en ? WRITE : IDLE;
                    cyc   <= en;
                end
                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign wshb_ifm.cyc    = cyc;
    assign wshb_ifm.stb    = cyc;
    assign wshb_ifm.we     = cyc;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.dat_ms = dat;
    assign wshb_ifm.cti    = WB_CTI_CLASSIC;
    assign wshb_ifm.bte    = WB_BTE_LINEAR;

endmodule

// File: tb/tb_wshb_mire.sv
// Randomised bench for wshb_mire: a pixel-index model predicts every write,
// burst release, frame pulse and bus hold against a random-ack slave.
module tb_wshb_mire;

    localparam int          H    = 20;
    localparam int          V    = 3;
    localparam int          BL   = 7;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NPIX = H * V;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic ack;
    logic frame_done;

    wshb_if bus();
    assign bus.ack = ack;

    wshb_mire #(
        .HDISP     (H),
        .VDISP     (V),
        .BASE_ADR  (BASE),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wshb_ifm   (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: index of the pixel being offered, acks in burst.
    int p     = 0;
    int burst = 0;
    bit prev_cyc = 1'b0;
    bit prev_ack = 1'b0;
    bit prev_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_adr(input int idx);
        return BASE + 32'(idx) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_dat(input int idx);
        int x = idx % H;
        int y = idx / H;
        return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    // One clock: judge what the last edge did, then drive the next inputs.
    task automatic step(input int en_pct, input int ack_pct);
        bit taken;
        bit rel;
        bit exp_fd;
        @(negedge clk);
        taken  = prev_cyc && prev_ack;
        rel    = 1'b0;
        exp_fd = 1'b0;
        if (taken) begin
            exp_fd = (p == NPIX - 1);
            p      = (p + 1) % NPIX;
            burst++;
            if (burst == BL) begin
                burst = 0;
                rel   = 1'b1;
            end
        end
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (rel)
            check("release_cyc_low", 32'(bus.cyc), 32'd0);
        else if (prev_cyc && !prev_ack)
            check("hold_cyc", 32'(bus.cyc), 32'd1);
        else
            check("cyc_follows_en", 32'(bus.cyc), 32'(prev_en));
        check("stb_eq_cyc", 32'(bus.stb), 32'(bus.cyc));
        if (bus.cyc) begin
            check("adr", bus.adr, exp_adr(p));
            check("dat", bus.dat_ms, exp_dat(p));
            check("we_sel_cti_bte", {22'd0, bus.we, bus.sel, bus.cti, bus.bte}, {22'd0, 1'b1, 4'hF, 3'b000, 2'b00});
        end
        en  = ($urandom_range(0, 99) < en_pct);
        ack = bus.cyc && bus.stb && ($urandom_range(0, 99) < ack_pct);
        prev_cyc = bus.cyc;
        prev_ack = ack;
        prev_en  = en;
    endtask

    task automatic run(input int n, input int en_pct, input int ack_pct);
        for (int i = 0; i < n; i++) step(en_pct, ack_pct);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cyc", 32'(bus.cyc), 32'd0);
        check("reset_stb", 32'(bus.stb), 32'd0);
        check("reset_we", 32'(bus.we), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        run(150, 100, 100);   // back-to-back acks, bursts and frame wraps
        run(20, 100, 0);      // ack withheld: bus must hold still
        run(60, 100, 100);
        run(12, 0, 0);        // en dropped with a transfer pending
        run(40, 0, 100);
        run(60, 100, 100);    // resume where it stopped
        run(1500, 90, 70);
        run(300, 30, 50);

        // Asynchronous reset while a transfer is pending.
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                step(100, 0);
                seen = bus.cyc;
            end
            check("wait_cyc_before_reset", 32'(seen), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_cyc", 32'(bus.cyc), 32'd0);
        check("async_reset_stb", 32'(bus.stb), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        p        = 0;
        burst    = 0;
        ack      = 1'b0;
        prev_cyc = 1'b0;
        prev_ack = 1'b0;
        prev_en  = en;
        run(200, 100, 100);
        run(600, 80, 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
